// File: rtl/stream_mux_rr_if.sv
// Bundle of the N producer streams and the single consumer stream around stream_mux_rr.
// in_last/out_last exist only when STMUX_PKT_LOCK_EN is defined.
interface stream_mux_rr_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_chan;
`ifdef STMUX_PKT_LOCK_EN
    logic [N-1:0]       in_last;
    logic               out_last;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_chan, out_last
    );
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_chan, out_last
    );
`else
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
`endif
endinterface

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux with a one-entry output register and select or round-robin
// arbitration. Define STMUX_PKT_LOCK_EN to hold the grant on one channel until in_last.
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [$clog2(N)-1:0] sel,
    stream_mux_rr_if.slave       bus
);
    localparam int SELW = $clog2(N);

    logic             load_en_s;
    logic             xfer_s;
    logic             sel_ok_s;
    logic             rr_ok_s;
    logic             gnt_ok_s;
    logic [SELW-1:0]  rr_gnt_s;
    logic [SELW-1:0]  gnt_s;
    logic [SELW-1:0]  idx_s;
    logic [N-1:0]     ready_s;
    logic [WIDTH-1:0] gnt_data_s;
    logic [SELW-1:0]  ptr_r;
    logic [SELW-1:0]  out_chan_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;
`ifdef STMUX_PKT_LOCK_EN
    logic             lock_r;
    logic [SELW-1:0]  lock_ch_r;
    logic             out_last_r;
`endif

    assign load_en_s  = !out_valid_r || bus.out_ready;
    assign sel_ok_s   = (int'(sel) < N) ? bus.in_valid[sel] : 1'b0;
    assign gnt_data_s = bus.in_data[int'(gnt_s)*WIDTH +: WIDTH];

    // Round-robin search: scanning from farthest to nearest lets the channel right after ptr win.
    always_comb begin
        rr_gnt_s = '0;
        rr_ok_s  = 1'b0;
        idx_s    = '0;
        for (int k = N; k >= 1; k--) begin
            idx_s = SELW'((int'(ptr_r) + k) % N);
            if (bus.in_valid[idx_s]) begin
                rr_gnt_s = idx_s;
                rr_ok_s  = 1'b1;
            end else begin
                rr_gnt_s = rr_gnt_s;
                rr_ok_s  = rr_ok_s;
            end
        end
    end

    // Final grant: mode choice, overridden by an open packet lock.
    always_comb begin
        gnt_s    = '0;
        gnt_ok_s = 1'b0;
        if (mode) begin
            gnt_s    = rr_gnt_s;
            gnt_ok_s = rr_ok_s;
        end else begin
            gnt_s    = sel;
            gnt_ok_s = sel_ok_s;
        end
`ifdef STMUX_PKT_LOCK_EN
        if (lock_r) begin
            gnt_s    = lock_ch_r;
            gnt_ok_s = bus.in_valid[lock_ch_r];
        end else begin
            gnt_s    = gnt_s;
            gnt_ok_s = gnt_ok_s;
        end
`endif
    end

    // One-hot ready toward the granted producer, blocked during reset.
    always_comb begin
        ready_s = '0;
        for (int i = 0; i < N; i++) begin
            ready_s[i] = !rst && load_en_s && gnt_ok_s && (gnt_s == SELW'(i));
        end
    end

    assign bus.in_ready = ready_s;
    assign xfer_s       = |(ready_s & bus.in_valid);

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_chan_r  <= '0;
            ptr_r       <= SELW'(N - 1);
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= gnt_data_s;
            out_chan_r  <= gnt_s;
            ptr_r       <= gnt_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef STMUX_PKT_LOCK_EN
    // Packet lock opens on a non-last beat and closes on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_r     <= 1'b0;
            lock_ch_r  <= '0;
            out_last_r <= 1'b0;
        end else if (xfer_s) begin
            lock_r     <= !bus.in_last[gnt_s];
            lock_ch_r  <= gnt_s;
            out_last_r <= bus.in_last[gnt_s];
        end
    end

    assign bus.out_last = out_last_r;
`endif

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_chan  = out_chan_r;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomised self-checking bench for stream_mux_rr: cycle-level reference model plus
// directed literal checks for reset, select, backpressure, mid-run reset, mode switch and lock.
module tb_stream_mux_rr;
    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SELW  = $clog2(N);

    logic            clk  = 1'b0;
    logic            rst  = 1'b0;
    logic            mode = 1'b0;
    logic [SELW-1:0] sel  = '0;

    int checks = 0;
    int errors = 0;

    // reference model state (state as seen after the most recent rising edge)
    bit m_valid;
    int m_data, m_chan, m_ptr, m_lock, m_lock_ch, m_last;

    stream_mux_rr_if #(.WIDTH(WIDTH), .N(N)) bus ();

    stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .sel  (sel),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner under the arbitration rules, or -1 when nobody is granted.
    function automatic int model_grant();
        if (m_lock != 0) return bus.in_valid[m_lock_ch] ? m_lock_ch : -1;
        if (mode == 1'b0) return (int'(sel) < N && bus.in_valid[sel]) ? int'(sel) : -1;
        for (int k = 1; k <= N; k++) begin
            if (bus.in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Compare DUT against the model mid-cycle, then advance the model across the next edge.
    always @(negedge clk) begin
        int           g;
        bit           load;
        logic [N-1:0] exp_rdy;
        if (rst) begin
            chk("rst_out_valid", bus.out_valid, 1'b0);
            chk("rst_in_ready", bus.in_ready, '0);
            m_valid = 1'b0; m_data = 0; m_chan = 0; m_ptr = N - 1;
            m_lock = 0; m_lock_ch = 0; m_last = 0;
        end else begin
            load    = !m_valid || bus.out_ready;
            g       = model_grant();
            exp_rdy = '0;
            if (load && g >= 0) exp_rdy[g] = 1'b1;
            chk("in_ready", bus.in_ready, exp_rdy);
            chk("out_valid", bus.out_valid, m_valid);
            if (m_valid) begin
                chk("out_data", bus.out_data, m_data);
                chk("out_chan", bus.out_chan, m_chan);
`ifdef STMUX_PKT_LOCK_EN
                chk("out_last", bus.out_last, m_last);
`endif
            end
            if (load && g >= 0) begin
                m_valid = 1'b1;
                m_data  = int'(bus.in_data[g*WIDTH +: WIDTH]);
                m_chan  = g;
                m_ptr   = g;
`ifdef STMUX_PKT_LOCK_EN
                m_last    = int'(bus.in_last[g]);
                m_lock    = (m_last == 0) ? 1 : 0;
                m_lock_ch = g;
`endif
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
`ifdef STMUX_PKT_LOCK_EN
        bus.in_last   = '1;
`endif
        #1 rst = 1'b1;
        #2;
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_out_data", bus.out_data, 8'h00);
        chk("reset_out_chan", bus.out_chan, 2'd0);
        chk("reset_in_ready", bus.in_ready, 4'b0000);

        // round-robin from reset: channel 0 first, then in order at full rate
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; mode = 1'b1; bus.in_valid = 4'b1111;
        bus.in_data = 32'h44332211; bus.out_ready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr_seq_chan", bus.out_chan, i % 4);
            chk("rr_seq_data", bus.out_data, (i % 4 + 1) * 17);
            chk("rr_onehot", $countones(bus.in_ready), 1);
        end

        // select mode
        @(posedge clk); #1;
        mode = 1'b0; sel = 2'd2; bus.in_valid = 4'b0100; bus.in_data = 32'h00A50000;
        @(negedge clk);
        chk("sel_ready", bus.in_ready, 4'b0100);
        @(posedge clk); #1;
        bus.in_valid = 4'b0010;
        @(negedge clk);
        chk("sel_data", bus.out_data, 8'hA5);
        chk("sel_chan", bus.out_chan, 2'd2);
        chk("sel_other_ready", bus.in_ready, 4'b0000);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sel_no_xfer", bus.out_valid, 1'b0);

        // backpressure: one beat held for 5 cycles
        @(posedge clk); #1;
        bus.out_ready = 1'b0; bus.in_valid = 4'b0100; bus.in_data = 32'h003C0000;
        @(posedge clk); #1;
        bus.in_data = 32'h00770000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_data", bus.out_data, 8'h3C);
            chk("bp_ready_low", bus.in_ready, 4'b0000);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1; bus.in_valid = 4'b0000;
        @(negedge clk);
        chk("bp_release_valid", bus.out_valid, 1'b1);
        chk("bp_release_data", bus.out_data, 8'h3C);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_no_dup", bus.out_valid, 1'b0);

        // mid-run reset while a beat is held
        @(posedge clk); #1;
        mode = 1'b1; bus.in_valid = 4'b1111; bus.in_data = 32'h44332211; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", bus.out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", bus.out_valid, 1'b0);
        chk("async_rst_ready", bus.in_ready, 4'b0000);
        @(posedge clk); #1;
        rst = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_chan", bus.out_chan, 2'd0);

        // mode switch: rr ch1, select ch3, rr resumes at ch0
        @(posedge clk); #1;
        mode = 1'b0; sel = 2'd3;
        @(negedge clk);
        chk("msw_rr_chan", bus.out_chan, 2'd1);
        @(posedge clk); #1;
        mode = 1'b1;
        @(negedge clk);
        chk("msw_sel_chan", bus.out_chan, 2'd3);
        @(posedge clk); #1;
        @(negedge clk);
        chk("msw_rr_wrap_chan", bus.out_chan, 2'd0);

`ifdef STMUX_PKT_LOCK_EN
        // packet lock: ch1 holds the grant for 3 beats, then ch2
        @(posedge clk); #1;
        rst = 1'b1; bus.in_valid = 4'b0000; bus.in_last = 4'b1111; mode = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 4'b0001;
        @(posedge clk); #1;
        bus.in_valid = 4'b0111; bus.in_last = 4'b1101; bus.in_data = 32'h00332211;
        @(posedge clk); #1;
        @(negedge clk);
        chk("lock_b1_chan", bus.out_chan, 2'd1);
        chk("lock_b1_last", bus.out_last, 1'b0);
        @(posedge clk); #1;
        bus.in_last = 4'b1111;
        @(negedge clk);
        chk("lock_b2_chan", bus.out_chan, 2'd1);
        chk("lock_b2_last", bus.out_last, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lock_b3_chan", bus.out_chan, 2'd1);
        chk("lock_b3_last", bus.out_last, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lock_after_chan", bus.out_chan, 2'd2);
`endif

        // randomised traffic with occasional resets, checked by the model
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel           = SELW'($urandom);
            bus.in_valid  = N'($urandom);
            bus.in_data   = (N*WIDTH)'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
`ifdef STMUX_PKT_LOCK_EN
            bus.in_last   = N'($urandom);
`endif
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
